mem_burst_ctrl: RTL and testbench

Initiator-side sequencer for the 32x8 scratch memory. It accepts single or burst read/write commands from the CPU datapath over valid/ready handshakes. It then drives the memory's `re`/`we`/`addr`/`din` pins one beat per cycle and streams read data back through a registered output stage. It sits between the CPU control unit and the memory array and owns all memory pin activity.

---
 rtl/mem_burst_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: initiator-side sequencer for the 32x8 scratch memory.
// Accepts single or burst read/write commands over valid/ready handshakes,
// drives the memory pins one beat per cycle and returns read data through
// a registered output stage.
//
// Handshake rule for every channel (cmd, wr, rd): a transfer happens on a
// rising clk edge where both valid and ready are high; a valid source holds
// its payload stable until that edge.
//
// Optional feature macro: MEM_CTRL_BOUND_EN. When it is defined, a burst whose
// start address plus length runs past the top of memory is rejected with
// err. When it is not defined, such bursts wrap from the top address to 0.
module mem_burst_ctrl #(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int MAXLEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [3:0]    cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          done,
  output logic          err,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] cur_addr_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          rd_last_q;
  logic          err_q;

  logic          cmd_bad;
  logic          issue;
  logic [AW-1:0] addr_d;
  logic [3:0]    cnt_d;

  // A new read may be issued whenever the output stage is empty or is
  // being emptied in this same cycle.
  assign issue = !rd_valid_q || rd_ready;

  // Per-beat address/count advance; address wraps modulo 2^AW.
  assign addr_d = cur_addr_q + 1'b1;
  assign cnt_d  = cnt_q - 4'd1;

  // Command legality: length must be 1..MAXLEN (and optionally in bounds).
  always_comb begin
    cmd_bad = (cmd_len == 4'd0) || (int'(cmd_len) > MAXLEN);
`ifdef MEM_CTRL_BOUND_EN
    if ((int'(cmd_addr) + int'(cmd_len)) > (1 << AW)) begin
      cmd_bad = 1'b1;
    end
`else
    cmd_bad = cmd_bad;
`endif
  end

  // Memory pins are combinational so a write commits on the beat's accept edge
  // and read data is captured on the issue edge; pins are quiet elsewhere.
  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state_q)
      S_WR: begin
        mem_we   = wr_valid;
        mem_addr = cur_addr_q;
        mem_din  = wr_data;
      end
      S_RD: begin
        mem_re   = issue;
        mem_addr = cur_addr_q;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Status outputs decoded straight from the state register.
  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WR);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign dbg_state = state_q;

  // Burst sequencer: command capture, beat counting and read output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_addr_q <= cmd_addr;
            cnt_q      <= cmd_len;
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else if (cmd_write) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_WR: begin
          if (wr_valid) begin
            cur_addr_q <= addr_d;
            cnt_q      <= cnt_d;
            if (cnt_q == 4'd1) begin
              state_q <= S_DONE;
            end
          end
        end
        S_RD: begin
          if (issue) begin
            rd_data_q  <= mem_dout;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (cnt_q == 4'd1);
            cur_addr_q <= addr_d;
            cnt_q      <= cnt_d;
            if (cnt_q == 4'd1) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (rd_valid_q && rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bench for mem_burst_ctrl with a 32x8 memory model.
module tb_mem_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [4:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       done, err, mem_re, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  mem_burst_ctrl #(.AW(5), .DW(8), .MAXLEN(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  // Scratch memory model: synchronous write, combinational read under re.
  logic [7:0] mem [0:31];
  assign mem_dout = mem_re ? mem[mem_addr] : 8'h00;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  function automatic logic [7:0] init_val(int i);
    return 8'h40 + 8'(i);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'd0; cmd_len = 4'd0;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
  endtask

  // Reset values of every output, packed: cmd_ready..dbg_state.
  task automatic test_reset;
    logic [31:0] obs, exp;
    rst = 1'b1;
    idle_inputs();
    #2;
    obs = {cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, err,
           mem_re, mem_we, mem_addr, mem_din, dbg_state};
    exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 3'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs, exp);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got cmd_ready=%b done=%b exp 1 0", cmd_ready, done);
    end
  endtask

  task automatic test_write;
    logic [7:0] d [3];
    d = '{8'hA1, 8'hA2, 8'hA3};
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd4; cmd_len = 4'd3;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = d[i];
      #1;
      checks++;
      if ({wr_ready, mem_we, mem_re, mem_addr, mem_din, done} !== {1'b1, 1'b1, 1'b0, 5'(4 + i), d[i], 1'b0}) begin
        errors++;
        $display("FAIL wr_beat%0d got rdy=%b we=%b re=%b addr=%0d din=%h done=%b exp 1 1 0 %0d %h 0",
                 i, wr_ready, mem_we, mem_re, mem_addr, mem_din, done, 4 + i, d[i]);
      end
      tick();
    end
    wr_valid = 1'b0;
    #1;
    checks++;
    if ({done, cmd_ready, mem_we, wr_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL wr_done got done=%b cmd_ready=%b we=%b wr_ready=%b exp 1 0 0 0",
               done, cmd_ready, mem_we, wr_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_done_once got done=%b cmd_ready=%b exp 0 1", done, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[4 + i] !== d[i]) begin
        errors++;
        $display("FAIL wr_mem%0d got %h exp %h", 4 + i, mem[4 + i], d[i]);
      end
    end
  endtask

  // Read with rd_ready held high: expected per cycle k=1..5 after acceptance.
  task automatic test_read;
    logic       e_re [5], e_vld [5], e_last [5], e_done [5];
    logic [4:0] e_addr [5];
    logic [7:0] e_data [5];
    e_re   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e_addr = '{5'd4, 5'd5, 5'd6, 5'd0, 5'd0};
    e_vld  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    e_data = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    e_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rd_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd4; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({mem_re, mem_we, mem_addr, rd_valid, rd_last, done} !==
          {e_re[k], 1'b0, e_addr[k], e_vld[k], e_last[k], e_done[k]}) begin
        errors++;
        $display("FAIL rd_cyc%0d got re=%b we=%b addr=%0d vld=%b last=%b done=%b exp %b 0 %0d %b %b %b",
                 k + 1, mem_re, mem_we, mem_addr, rd_valid, rd_last, done,
                 e_re[k], e_addr[k], e_vld[k], e_last[k], e_done[k]);
      end
      if (e_vld[k]) begin
        checks++;
        if (rd_data !== e_data[k]) begin
          errors++;
          $display("FAIL rd_data_cyc%0d got %h exp %h", k + 1, rd_data, e_data[k]);
        end
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  // Read with rd_ready = 1 on odd cycles, 0 on even cycles after acceptance.
  task automatic test_read_stall;
    logic       e_re [8], e_vld [8], e_last [8], e_done [8];
    logic [4:0] e_addr [8];
    logic [7:0] e_data [8];
    e_re   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e_addr = '{5'd4, 5'd5, 5'd5, 5'd6, 5'd6, 5'd0, 5'd0, 5'd0};
    e_vld  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_data = '{8'h00, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'h00};
    e_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    e_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd4; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_ready = ((k + 1) % 2 == 1);
      #1;
      checks++;
      if ({mem_re, mem_we, rd_valid, rd_last, done} !==
          {e_re[k], 1'b0, e_vld[k], e_last[k], e_done[k]}) begin
        errors++;
        $display("FAIL stall_cyc%0d got re=%b we=%b vld=%b last=%b done=%b exp %b 0 %b %b %b",
                 k + 1, mem_re, mem_we, rd_valid, rd_last, done,
                 e_re[k], e_vld[k], e_last[k], e_done[k]);
      end
      if (e_re[k]) begin
        checks++;
        if (mem_addr !== e_addr[k]) begin
          errors++;
          $display("FAIL stall_addr_cyc%0d got %0d exp %0d", k + 1, mem_addr, e_addr[k]);
        end
      end
      if (e_vld[k]) begin
        checks++;
        if (rd_data !== e_data[k]) begin
          errors++;
          $display("FAIL stall_data_cyc%0d got %h exp %h", k + 1, rd_data, e_data[k]);
        end
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_err;
    logic [3:0] lens [2];
    lens = '{4'd0, 4'd9};
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_write = (i == 0); cmd_addr = 5'd2; cmd_len = lens[i];
      wr_valid = 1'b1; wr_data = 8'hFF;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("FAIL err_len%0d_accept got cmd_ready=%b err=%b exp 1 0", lens[i], cmd_ready, err);
      end
      tick();
      cmd_valid = 1'b0;
      #1;
      checks++;
      if ({err, cmd_ready, mem_re, mem_we, dbg_state} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL err_len%0d_pulse got err=%b cmd_ready=%b re=%b we=%b st=%0d exp 1 1 0 0 0",
                 lens[i], err, cmd_ready, mem_re, mem_we, dbg_state);
      end
      tick();
      checks++;
      if ({err, mem_re, mem_we, wr_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL err_len%0d_after got err=%b re=%b we=%b wr_ready=%b exp 0 0 0 0",
                 lens[i], err, mem_re, mem_we, wr_ready);
      end
      wr_valid = 1'b0;
    end
  endtask

  task automatic test_wrap;
    logic [7:0] d [4];
    logic [4:0] a [4];
    d = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    a = '{5'd30, 5'd31, 5'd0, 5'd1};
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd30; cmd_len = 4'd4;
    tick();
    cmd_valid = 1'b0;
`ifdef MEM_CTRL_BOUND_EN
    checks++;
    if (err !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_reject got err=%b cmd_ready=%b exp 1 1", err, cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = d[i];
      #1;
      checks++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL wrap_no_we%0d got %b exp 0", i, mem_we);
      end
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[a[i]] !== init_val(int'(a[i]))) begin
        errors++;
        $display("FAIL wrap_mem%0d got %h exp %h", a[i], mem[a[i]], init_val(int'(a[i])));
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = d[i];
      #1;
      checks++;
      if ({mem_we, mem_addr, mem_din} !== {1'b1, a[i], d[i]}) begin
        errors++;
        $display("FAIL wrap_beat%0d got we=%b addr=%0d din=%h exp 1 %0d %h",
                 i, mem_we, mem_addr, mem_din, a[i], d[i]);
      end
      tick();
    end
    wr_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done got %b exp 1", done);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[a[i]] !== d[i]) begin
        errors++;
        $display("FAIL wrap_mem%0d got %h exp %h", a[i], mem[a[i]], d[i]);
      end
    end
`endif
  endtask

  task automatic test_rst_abort;
    logic [31:0] obs, exp;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd10; cmd_len = 4'd5;
    tick();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hC0;
    tick();
    wr_data = 8'hC1;
    tick();
    wr_data = 8'hC2;
    #1;
    rst = 1'b1;
    #1;
    obs = {cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, err,
           mem_re, mem_we, mem_addr, mem_din, dbg_state};
    exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 3'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_outputs got %h exp %h", obs, exp);
    end
    tick();
    rst = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({done, mem_we, mem_re, dbg_state} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL abort_quiet%0d got done=%b we=%b re=%b st=%0d exp 0 0 0 0",
                 i, done, mem_we, mem_re, dbg_state);
      end
    end
    checks++;
    if (mem[10] !== 8'hC0 || mem[11] !== 8'hC1) begin
      errors++;
      $display("FAIL abort_written got %h %h exp c0 c1", mem[10], mem[11]);
    end
    for (int i = 12; i < 15; i++) begin
      checks++;
      if (mem[i] !== init_val(i)) begin
        errors++;
        $display("FAIL abort_untouched%0d got %h exp %h", i, mem[i], init_val(i));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = init_val(i);
    test_reset();
    test_write();
    test_read();
    test_read_stall();
    test_err();
    test_wrap();
    test_rst_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
